conv_encoder_k3: RTL

Rate-1/2, constraint-length-3 convolutional encoder that produces the 2-bit channel symbols consumed by the Viterbi decoder datapath. It accepts one information bit per handshake and emits one registered 2-bit symbol per bit. Each frame of FRAME_LEN bits is terminated with K-1 = 2 zero tail bits, so the decoder's trellis always starts and ends in state 0. The block sits at the transmit end of the link and is also the golden stimulus source for decoder benches.

---
 rtl/conv_encoder_k3.sv | 92 +++++++++
 1 files changed

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder with per-frame zero-tail termination.
// One information bit per handshake in, one registered 2-bit symbol out.
module conv_encoder_k3 #(
  parameter int unsigned FRAME_LEN = 32,
  parameter logic [2:0]  G0        = 3'b111,
  parameter logic [2:0]  G1        = 3'b101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] out_sym,
  output logic       out_sof,
  output logic       out_eof,
  input  logic       out_ready
);

  localparam int unsigned CntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

  state_e          state_q;
  logic            s1_q, s0_q;
  logic            tail_q;
  logic [CntW-1:0] cnt_q;

  logic       slot_free, accept, tail_gen, load, u, last_bit;
  logic [2:0] v;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !reset && (state_q != StTail) && slot_free;
  assign accept    = in_valid && in_ready;
  assign tail_gen  = (state_q == StTail) && slot_free;
  assign load      = accept || tail_gen;
  // Tail symbols flush the trellis with u = 0.
  assign u         = accept & in_bit;
  assign v         = {u, s1_q, s0_q};
  assign last_bit  = (cnt_q == CntW'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      s1_q      <= 1'b0;
      s0_q      <= 1'b0;
      tail_q    <= 1'b0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_sym   <= 2'b00;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_sym   <= {^(v & G0), ^(v & G1)};
        out_sof   <= accept && (state_q == StIdle);
        out_eof   <= tail_gen && tail_q;
        s1_q      <= u;
        s0_q      <= s1_q;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_eof   <= 1'b0;
      end

      if (accept) begin
        if (last_bit) begin
          state_q <= StTail;
          cnt_q   <= '0;
        end else begin
          state_q <= StData;
          cnt_q   <= cnt_q + 1'b1;
        end
      end

      if (tail_gen) begin
        if (tail_q) begin
          // Second tail symbol loaded: next frame starts from state 0.
          state_q <= StIdle;
          tail_q  <= 1'b0;
          s1_q    <= 1'b0;
          s0_q    <= 1'b0;
          cnt_q   <= '0;
        end else begin
          tail_q  <= 1'b1;
        end
      end
    end
  end

endmodule
